// File: rtl/icache_nway_fill.sv
`default_nettype none
// ============================================================================
//  Module      : icache_nway_fill
//  Description : N-way set-associative read-only instruction cache. Hits
//                return one instruction in the same cycle. A miss fetches a
//                whole line with one bus burst, commits it into a victim way
//                (lowest invalid way, else per-set round-robin) and then
//                serves the fetch.
//  Options     : define ICACHE_PERF_EN to add the perf_hits / perf_misses
//                saturating event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_nway_fill #(
    parameter int WAYS           = 2,
    parameter int SETS           = 512,
    parameter int LINE_BYTES     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int INSTR_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     pc,
    input  logic                      pc_valid,
    input  logic                      flush,
    output logic [INSTR_WIDTH-1:0]    instr,
    output logic                      instr_valid,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]               perf_hits,
    output logic [31:0]               perf_misses
`endif
);

    // Geometry
    localparam int c_OFS   = $clog2(LINE_BYTES);
    localparam int c_IDX   = $clog2(SETS);
    localparam int c_TAGW  = ADDR_WIDTH - c_IDX - c_OFS;
    localparam int c_BEATS = LINE_BYTES * 8 / BUS_DATA_WIDTH;
    localparam int c_LINEW = LINE_BYTES * 8;
    localparam int c_WORDS = c_LINEW / INSTR_WIDTH;
    localparam int c_WOFS  = $clog2(INSTR_WIDTH / 8);
    localparam int c_BCW   = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Bus request tag: read command in bits [11:8], memory space in bit 12
    localparam logic [3:0] c_SYSBUS_READ   = 4'h1;
    localparam logic       c_SYSBUS_MEMORY = 1'b1;
    localparam logic [BUS_TAG_WIDTH-1:0] c_REQTAG =
        BUS_TAG_WIDTH'({c_SYSBUS_MEMORY, c_SYSBUS_READ, 8'h00});

    // FSM encoding
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REQ    = 2'd1;
    localparam logic [1:0] c_FILL   = 2'd2;
    localparam logic [1:0] c_COMMIT = 2'd3;

    // State and storage
    logic [1:0]                r_state;
    logic [c_BCW-1:0]          r_bcnt;
    logic [ADDR_WIDTH-1:0]     r_miss_addr;
    logic                      r_flush_pend;
    logic [SETS-1:0][WAYS-1:0] r_valid;
    logic [c_WAYW-1:0]         r_rr   [SETS];
    logic [c_TAGW-1:0]         r_tag  [WAYS][SETS];
    logic [c_LINEW-1:0]        r_data [WAYS][SETS];
    logic [BUS_DATA_WIDTH-1:0] r_fill [c_BEATS];

    // Lookup side
    logic [c_IDX-1:0]          w_set;
    logic [c_TAGW-1:0]         w_pc_tag;
    logic [c_OFS-c_WOFS-1:0]   w_wsel;
    logic                      w_lookup_hit;
    logic                      w_hit;
    logic [c_LINEW-1:0]        w_hit_line;
    logic [INSTR_WIDTH-1:0]    w_words [c_WORDS];

    // Fill / commit side
    logic [c_IDX-1:0]          w_miss_set;
    logic [c_TAGW-1:0]         w_miss_tag;
    logic [c_LINEW-1:0]        w_fill_line;
    logic [c_WAYW-1:0]         w_victim;
    logic                      w_all_valid;
    logic [c_WAYW-1:0]         w_rr_next;
    logic                      w_commit_ok;
    logic                      w_miss_start;

    assign w_set      = pc[c_IDX+c_OFS-1:c_OFS];
    assign w_pc_tag   = pc[ADDR_WIDTH-1 -: c_TAGW];
    assign w_wsel     = pc[c_OFS-1:c_WOFS];
    assign w_miss_set = r_miss_addr[c_IDX+c_OFS-1:c_OFS];
    assign w_miss_tag = r_miss_addr[ADDR_WIDTH-1 -: c_TAGW];

    // Word-aligned pc bits below the instruction size and the response tag carry no information
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, pc[c_WOFS-1:0], bus_resptag};

    // Tag compare across all ways of the addressed set
    always_comb begin
        w_lookup_hit = 1'b0;
        w_hit_line   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_set][w] && (r_tag[w][w_set] == w_pc_tag)) begin
                w_lookup_hit = 1'b1;
                w_hit_line   = r_data[w][w_set];
            end
        end
    end

    assign w_hit        = (r_state == c_IDLE) && pc_valid && w_lookup_hit;
    assign w_miss_start = (r_state == c_IDLE) && pc_valid && !w_lookup_hit && !flush;

    generate
        for (genvar i = 0; i < c_WORDS; i++) begin : g_words
            assign w_words[i] = w_hit_line[i*INSTR_WIDTH +: INSTR_WIDTH];
        end
        for (genvar b = 0; b < c_BEATS; b++) begin : g_fill_line
            assign w_fill_line[b*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = r_fill[b];
        end
    endgenerate

    // Victim choice: lowest invalid way wins, otherwise the set's round-robin pointer
    always_comb begin
        w_victim    = r_rr[w_miss_set];
        w_all_valid = &r_valid[w_miss_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_miss_set][w]) begin
                w_victim = c_WAYW'(w);
            end
        end
        w_rr_next = (r_rr[w_miss_set] == c_WAYW'(WAYS - 1)) ? '0
                                                            : r_rr[w_miss_set] + c_WAYW'(1);
    end

    // A flush seen at any point of the burst (or on the commit cycle itself) drops the line
    assign w_commit_ok = !r_flush_pend && !flush;

    // Miss FSM, valid bits and replacement pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_bcnt       <= '0;
            r_miss_addr  <= '0;
            r_flush_pend <= 1'b0;
            r_valid      <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_miss_start) begin
                        r_miss_addr <= {pc[ADDR_WIDTH-1:c_OFS], {c_OFS{1'b0}}};
                        r_state     <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (bus_reqack) begin
                        r_bcnt  <= '0;
                        r_state <= c_FILL;
                    end
                end
                c_FILL: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (bus_respcyc) begin
                        if (r_bcnt == c_BCW'(c_BEATS - 1)) begin
                            r_bcnt  <= '0;
                            r_state <= c_COMMIT;
                        end else begin
                            r_bcnt <= r_bcnt + c_BCW'(1);
                        end
                    end
                end
                default: begin
                    if (w_commit_ok) begin
                        r_valid[w_miss_set][w_victim] <= 1'b1;
                        if (w_all_valid) r_rr[w_miss_set] <= w_rr_next;
                    end
                    r_flush_pend <= 1'b0;
                    r_state      <= c_IDLE;
                end
            endcase
            if (flush) r_valid <= '0;
        end
    end

    // Beat capture and line/tag write; array contents are qualified by the valid bits
    always_ff @(posedge clk) begin
        if (r_state == c_FILL && bus_respcyc) begin
            r_fill[r_bcnt] <= bus_resp;
        end
        if (r_state == c_COMMIT && w_commit_ok) begin
            r_data[w_victim][w_miss_set] <= w_fill_line;
            r_tag[w_victim][w_miss_set]  <= w_miss_tag;
        end
    end

    assign instr       = w_hit ? w_words[w_wsel] : '0;
    assign instr_valid = w_hit;
    assign bus_reqcyc  = (r_state == c_REQ);
    assign bus_req     = (r_state == c_REQ) ? BUS_DATA_WIDTH'(r_miss_addr) : '0;
    assign bus_reqtag  = (r_state == c_REQ) ? c_REQTAG : '0;
    assign bus_respack = (r_state == c_FILL) && bus_respcyc;

`ifdef ICACHE_PERF_EN
    logic [31:0] r_perf_hits;
    logic [31:0] r_perf_misses;

    // Saturating hit-cycle and miss-start counters, untouched by flush
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_hits   <= '0;
            r_perf_misses <= '0;
        end else begin
            if (w_hit && (r_perf_hits != '1))          r_perf_hits   <= r_perf_hits + 32'd1;
            if (w_miss_start && (r_perf_misses != '1)) r_perf_misses <= r_perf_misses + 32'd1;
        end
    end

    assign perf_hits   = r_perf_hits;
    assign perf_misses = r_perf_misses;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_nway_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_nway_fill
//  Description : Self-checking bench for icache_nway_fill (default geometry).
//                Acts as the bus slave; expected fetch words are queued when
//                a fetch is issued and compared when the cache returns them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_nway_fill;

    localparam logic [12:0] EXP_TAG = 13'h1100;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [31:0] instr;
    logic        instr_valid;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    icache_nway_fill dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory image: line 0x1000 holds beat i = i*0x0101..01, other lines are distinct
    function automatic logic [63:0] beat(input logic [63:0] line, input int i);
        logic [31:0] d;
        d = line[31:0] - 32'h1000;
        return (64'(i) * 64'h0101010101010101) ^ {d, d};
    endfunction

    function automatic logic [31:0] word_of(input logic [63:0] a);
        logic [63:0] b;
        b = beat({a[63:6], 6'b0}, int'(a[5:3]));
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    // One fetch; on a miss the bench serves the burst as bus slave
    task automatic fetch(input string tag, input logic [63:0] addr, input logic [31:0] exp_word,
                         input logic exp_hit, input int gap = 0, input int ack_dly = 0,
                         input int flush_beat = -1, input int reset_beat = -1);
        logic [63:0] line;
        logic [31:0] e;
        int          n;
        line = {addr[63:6], 6'b0};
        @(posedge clk); #1;
        pc       = addr;
        pc_valid = 1'b1;
        if (flush_beat < 0 && reset_beat < 0) exp_q.push_back(exp_word);
        @(negedge clk);
        check({tag, "_hit"}, 64'(instr_valid), 64'(exp_hit));
        if (!instr_valid) begin
            n = 0;
            while (!bus_reqcyc && n < 20) begin @(negedge clk); n++; end
            check({tag, "_reqcyc"}, 64'(bus_reqcyc), 64'd1);
            check({tag, "_reqaddr"}, bus_req, line);
            check({tag, "_reqtag"}, 64'(bus_reqtag), 64'(EXP_TAG));
            for (int k = 0; k < ack_dly; k++) begin
                @(negedge clk);
                check({tag, "_reqhold"}, {bus_reqcyc, bus_req}, {1'b1, line});
            end
            bus_reqack = 1'b1;
            @(negedge clk);
            bus_reqack = 1'b0;
            check({tag, "_reqdrop"}, 64'(bus_reqcyc), 64'd0);
            for (int i = 0; i < 8; i++) begin
                for (int g = 0; g < gap; g++) begin
                    bus_respcyc = 1'b0;
                    @(negedge clk);
                end
                bus_respcyc = 1'b1;
                bus_resp    = beat(line, i);
                if (i == flush_beat) flush = 1'b1;
                if (i == reset_beat) reset = 1'b1;
                if (i == 0) begin
                    #1 check({tag, "_respack"}, 64'(bus_respack), 64'd1);
                end
                @(negedge clk);
                flush = 1'b0;
                if (i == reset_beat) begin
                    check({tag, "_rst_reqcyc"}, 64'(bus_reqcyc), 64'd0);
                    check({tag, "_rst_ivalid"}, 64'(instr_valid), 64'd0);
                    reset       = 1'b0;
                    bus_respcyc = 1'b0;
                    pc_valid    = 1'b0;
                    return;
                end
            end
            bus_respcyc = 1'b0;
            if (flush_beat >= 0) begin
                pc_valid = 1'b0;
                return;
            end
            n = 0;
            while (!instr_valid && n < 20) begin @(negedge clk); n++; end
            check({tag, "_fill_hit"}, 64'(instr_valid), 64'd1);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (instr_valid) check({tag, "_instr"}, 64'(instr), 64'(e));
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        pc_valid = 1'b0;
    endtask

    task automatic flush_pulse();
        @(posedge clk); #1;
        pc_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        pc          = '0;
        pc_valid    = 1'b0;
        flush       = 1'b0;
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        bus_resptag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {bus_reqcyc, bus_respack, instr_valid, bus_reqtag, bus_req},
              '0);
        check("rst_instr", 64'(instr), 64'd0);
        reset = 1'b0;

        // Basic fill then word selection within the line
        fetch("t1_fill", 64'h1000, 32'h0000_0000, 1'b0);
        fetch("t1_w1",   64'h1004, 32'h0000_0000, 1'b1);
        fetch("t1_w3",   64'h100C, 32'h0101_0101, 1'b1);
        idle();

        // Three lines in set 64: fill order and round-robin eviction
        fetch("t2_fill_b",  64'h9000,  word_of(64'h9000),  1'b0);
        fetch("t2_fill_c",  64'h11000, word_of(64'h11000), 1'b0);
        fetch("t2_hit_b",   64'h9004,  word_of(64'h9004),  1'b1);
        fetch("t2_hit_c",   64'h11008, word_of(64'h11008), 1'b1);
        fetch("t2_miss_a",  64'h1000,  word_of(64'h1000),  1'b0);
        fetch("t2_keep_c",  64'h11010, word_of(64'h11010), 1'b1);
        fetch("t2_miss_b",  64'h9000,  word_of(64'h9000),  1'b0);
        fetch("t2_keep_a",  64'h1014,  word_of(64'h1014),  1'b1);
        fetch("t2_evict_c", 64'h11000, word_of(64'h11000), 1'b0);
        idle();

        // Stalled request and gapped beats give the same line contents
        flush_pulse();
        fetch("t3_fill", 64'h1000, 32'h0000_0000, 1'b0, 3, 5);
        fetch("t3_w3",   64'h100C, 32'h0101_0101, 1'b1);
        fetch("t3_w15",  64'h103C, 32'h0707_0707, 1'b1);
        idle();

        // Flush during a fill: burst completes, line is not kept, cache emptied
        fetch("t4_flushfill", 64'h2000, 32'h0, 1'b0, 0, 0, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_bus_idle", 64'(bus_reqcyc), 64'd0);
        end
        fetch("t4_refill", 64'h2000, word_of(64'h2000), 1'b0);
        fetch("t4_old",    64'h1000, word_of(64'h1000), 1'b0);
        idle();

        // Reset on the 4th beat abandons the fill and empties the cache
        fetch("t5_rstfill", 64'h3000, 32'h0, 1'b0, 0, 0, -1, 3);
        fetch("t5_old",     64'h2000, word_of(64'h2000), 1'b0);
        idle();

`ifdef ICACHE_PERF_EN
        // One miss followed by ten hit cycles
        @(posedge clk); #1;
        reset    = 1'b1;
        pc_valid = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b0;
        fetch("t6_miss", 64'h1000, word_of(64'h1000), 1'b0);
        for (int k = 1; k < 10; k++) begin
            fetch("t6_hit", 64'h1000 + 64'(4 * k), word_of(64'h1000 + 64'(4 * k)), 1'b1);
        end
        idle();
        @(negedge clk);
        check("t6_perf_misses", 64'(perf_misses), 64'd1);
        check("t6_perf_hits",   64'(perf_hits),   64'd10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
